rgb_light_arbiter: RTL and testbench
====================================

RGB_LIGHT_ARBITER -- requirements
Module: rgb_light_arbiter

Interface
REQ-001 SHALL have parameter HOLD_W, default 4: width of each per-requester dwell-count field.
REQ-002 SHALL have port clk  input  1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-004 SHALL have port req  input  3: req[i] high means requester i wants the shared light.
REQ-005 SHALL have port colour  input  9: colour[3i+2:3i] is the {R,G,B} request of requester i.
REQ-006 SHALL have port dwell  input  3*HOLD_W: field i is requester i's display length in cycles.
REQ-007 SHALL have port gnt  output  3: one-hot-or-zero, registered; the requester currently displayed.
REQ-008 SHALL have port done  output  3: registered one-cycle pulse; requester i's display completed normally.
REQ-009 SHALL have port rgb  output  3: registered drive to the shared RGB light.
REQ-010 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, SHOW and GAP.
REQ-012 In IDLE with any req bit high, SHALL pick a winner, latch its colour and dwell, and enter SHOW on the next edge.
REQ-013 In the first SHOW cycle, gnt[winner]=1 and rgb=the latched colour.
REQ-014 SHALL hold the SHOW state for exactly max(dwell,1) cycles; dwell=0 is treated as 1.
REQ-015 The colour and dwell inputs SHALL be sampled only at the grant decision; later changes SHALL be ignored.
REQ-016 On the final SHOW cycle, SHALL move to GAP; in GAP, rgb=000, gnt=000 and done[winner]=1, for exactly one cycle.
REQ-017 If req[winner] falls during SHOW, SHALL enter GAP on the next edge with done=000 (abort).
REQ-018 GAP SHALL always return to IDLE, so back-to-back displays are separated by one GAP cycle plus one IDLE cycle of rgb=000.
REQ-019 In IDLE, rgb=000 and gnt=000.
REQ-020 Requests arriving during SHOW or GAP SHALL wait; they are not lost while held high.
REQ-021 Arbitration SHALL be round-robin: after a grant to i, the priority order is i+1, i+2, i (mod 3).
REQ-022 The round-robin pointer SHALL update only on a grant, whether or not that display is later aborted.
REQ-023 The dwell counter SHALL be HOLD_W bits, count down and never wrap below zero.

Reset
REQ-024 Reset high at an edge SHALL force state=IDLE, gnt=000, done=000, rgb=000, busy=0 and counter=0.
REQ-025 Reset SHALL set the priority order to 0,1,2.
REQ-026 Reset SHALL override every other event, including mid-SHOW and GAP; no done pulse is produced for the interrupted display.
REQ-027 In the first cycle after reset is released, SHALL behave as IDLE.

Configuration
REQ-028 With macro RGB_ARB_PRIORITY_EN defined, requester 0 SHALL win every IDLE arbitration in which req[0]=1; the other requesters use round-robin among themselves.
REQ-029 With RGB_ARB_PRIORITY_EN undefined, arbitration SHALL be pure round-robin per REQ-021.
REQ-030 RGB_ARB_PRIORITY_EN SHALL NOT cause preemption of a display already in progress.

Structure
REQ-031 Package rgb_arb_pkg SHALL hold the state encoding (IDLE=0, SHOW=1, GAP=2), the constant RGB_OFF=3'b000 and the requester count 3.
REQ-032 Sub-module rr_picker (combinational: req, pointer -> one-hot winner) SHALL contain all arbitration logic, including the RGB_ARB_PRIORITY_EN branch.

Verification
REQ-033 Scenario, single display: req=001, colour0=101, dwell0=3 -> rgb=101 with gnt=001 for 3 cycles, then GAP with done=001 and rgb=000, then IDLE.
REQ-034 Scenario, round-robin: req=111 held, all dwell=1 -> grant order 0,1,2,0,1 with one GAP and one IDLE cycle between grants.
REQ-035 Scenario, dwell=0: dwell1=0, req=010 -> exactly 1 SHOW cycle, then done=010.
REQ-036 Scenario, abort: dwell2=8, req[2] dropped at SHOW cycle 3 -> GAP on the next edge, done=000, and the next grant starts after requester 2.
REQ-037 Scenario, reset mid-SHOW: reset pulsed at SHOW cycle 2 -> all outputs 0 on the next cycle, no done pulse, and a following req=111 grants requester 0.
REQ-038 Scenario, priority build: with RGB_ARB_PRIORITY_EN defined and req=111 held -> grant order 0,0,0; without it -> grant order 0,1,2.

Source files
------------

// File: rtl/rgb_arb_pkg.sv
// Shared definitions for rgb_light_arbiter: FSM state encoding, requester count,
// the light-off value and small index helpers used by the arbiter and its picker.
package rgb_arb_pkg;

    localparam int         NUM_REQ = 3;
    localparam logic [2:0] RGB_OFF = 3'b000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index of the set bit in a one-hot requester vector (0 for an empty vector).
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Requester that gets first priority after requester idx has been granted.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection for rgb_light_arbiter.
// Build option RGB_ARB_PRIORITY_EN: requester 0 wins whenever it is requesting.
module rr_picker
    import rgb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_winner
);

    logic [NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0] w_rot_win;
    logic [NUM_REQ-1:0] w_rr_win;

    // Rotate so bit 0 is the requester named by i_ptr, take the lowest set bit,
    // then rotate the one-hot result back to requester numbering.
    always_comb begin
        case (i_ptr)
            2'd1:    w_rot = {i_req[0], i_req[2], i_req[1]};
            2'd2:    w_rot = {i_req[1], i_req[0], i_req[2]};
            default: w_rot = i_req;
        endcase
    end

    assign w_rot_win = w_rot & (~w_rot + NUM_REQ'(1));

    always_comb begin
        case (i_ptr)
            2'd1:    w_rr_win = {w_rot_win[1], w_rot_win[0], w_rot_win[2]};
            2'd2:    w_rr_win = {w_rot_win[0], w_rot_win[2], w_rot_win[1]};
            default: w_rr_win = w_rot_win;
        endcase
    end

`ifdef RGB_ARB_PRIORITY_EN
    assign o_winner = i_req[0] ? NUM_REQ'(1) : w_rr_win;
`else
    assign o_winner = w_rr_win;
`endif

endmodule

// File: rtl/rgb_light_arbiter.sv
// Shares one RGB light between three requesters: grant, show for a dwell time, one GAP cycle.
// Build option RGB_ARB_PRIORITY_EN (handled in rr_picker) gives requester 0 absolute priority.
module rgb_light_arbiter
    import rgb_arb_pkg::*;
#(
    parameter int HOLD_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [3*NUM_REQ-1:0]    colour,
    input  logic [3*HOLD_W-1:0]     dwell,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [2:0]              rgb,
    output logic                    busy
);

    localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

    state_t             r_state, w_state_nxt;
    logic [HOLD_W-1:0]  r_cnt, w_cnt_nxt;
    logic [1:0]         r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0] r_done, w_done_nxt;
    logic [2:0]         r_rgb, w_rgb_nxt;

    logic [NUM_REQ-1:0] w_winner;
    logic [2:0]         w_sel_colour;
    logic [HOLD_W-1:0]  w_sel_dwell;

    rr_picker u_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner)
    );

    always_comb begin
        w_sel_colour = RGB_OFF;
        w_sel_dwell  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner[i]) begin
                w_sel_colour = colour[3*i +: 3];
                w_sel_dwell  = dwell[HOLD_W*i +: HOLD_W];
            end
        end
    end

    // NOTE: state registers use <= so every flop samples pre-edge values together.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and covers all state, including the pointer.
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= 2'd0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rgb   <= RGB_OFF;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_rgb   <= w_rgb_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block is assigned a default first so no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_rgb_nxt   = RGB_OFF;

        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = SHOW;
                    w_gnt_nxt   = w_winner;
                    w_rgb_nxt   = w_sel_colour;
                    w_cnt_nxt   = (w_sel_dwell == '0) ? CNT_ONE : w_sel_dwell;
                    w_ptr_nxt   = next_ptr(onehot_to_idx(w_winner));
                end
            end
            SHOW: begin
                // A dropped request aborts the display; the abort wins over completion.
                if ((req & r_gnt) == '0) begin
                    w_state_nxt = GAP;
                end else if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = GAP;
                    w_done_nxt  = r_gnt;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                    w_gnt_nxt = r_gnt;
                    w_rgb_nxt = r_rgb;
                end
            end
            GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign rgb  = r_rgb;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_rgb_light_arbiter.sv
// Self-checking bench for rgb_light_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a display-level reference model.
module tb_rgb_light_arbiter;

    localparam int HOLD_W = 4;
`ifdef RGB_ARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            req;
    logic [8:0]            colour;
    logic [3*HOLD_W-1:0]   dwell;
    logic [2:0]            gnt;
    logic [2:0]            done;
    logic [2:0]            rgb;
    logic                  busy;

    always #5 clk = ~clk;

    rgb_light_arbiter #(.HOLD_W(HOLD_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .colour (colour),
        .dwell  (dwell),
        .gnt    (gnt),
        .done   (done),
        .rgb    (rgb),
        .busy   (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: which requester is on display, how many display cycles
    // remain, whether the one-cycle gap is running, and who was granted last.
    int         m_cur  = -1;
    int         m_left = 0;
    int         m_last = 2;
    int         m_done = -1;
    bit         m_gap  = 1'b0;
    logic [2:0] m_col  = 3'b000;

    task automatic model_edge();
        int w;
        m_done = -1;
        if (reset) begin
            m_cur  = -1;
            m_gap  = 1'b0;
            m_last = 2;
            m_left = 0;
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_cur >= 0) begin
            if (!req[m_cur]) begin
                m_cur = -1;
                m_gap = 1'b1;
            end else if (m_left == 1) begin
                m_done = m_cur;
                m_cur  = -1;
                m_gap  = 1'b1;
            end else begin
                m_left--;
            end
        end else if (req != 3'b000) begin
            w = -1;
            if (PRIO && req[0]) w = 0;
            for (int k = 1; k <= 3; k++) begin
                if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
            end
            m_cur  = w;
            m_last = w;
            m_col  = colour[3*w +: 3];
            m_left = int'(dwell[HOLD_W*w +: HOLD_W]);
            if (m_left == 0) m_left = 1;
        end
    endtask

    task automatic compare(input string tag);
        logic [2:0] e_gnt, e_done, e_rgb;
        e_gnt  = 3'b000;
        e_done = 3'b000;
        e_rgb  = 3'b000;
        if (m_cur >= 0) begin
            e_gnt[m_cur] = 1'b1;
            e_rgb        = m_col;
        end
        if (m_done >= 0) e_done[m_done] = 1'b1;
        check({tag, ".gnt"},  32'(gnt),  32'(e_gnt));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".rgb"},  32'(rgb),  32'(e_rgb));
        check({tag, ".busy"}, 32'(busy), 32'((m_cur >= 0) || m_gap));
    endtask

    // One clock: model advances on the edge, outputs are compared on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick("rst");
        reset = 1'b0;
    endtask

    function automatic int oh_idx(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    initial begin
        int         order[$];
        int         last_start;
        logic [2:0] prev;

        reset  = 1'b1;
        req    = 3'b000;
        colour = '0;
        dwell  = '0;
        tick("rst");
        check("rst.gnt",  32'(gnt),  32'h0);
        check("rst.done", 32'(done), 32'h0);
        check("rst.rgb",  32'(rgb),  32'h0);
        check("rst.busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // Single display: colour 101 for 3 cycles, then GAP with done, then IDLE.
        colour = 9'b000_000_101;
        dwell  = {4'd0, 4'd0, 4'd3};
        req    = 3'b001;
        for (int i = 0; i < 3; i++) begin
            tick("s1");
            check("s1.rgb", 32'(rgb), 32'(3'b101));
            check("s1.gnt", 32'(gnt), 32'(3'b001));
            colour = 9'b111_111_010;
            dwell  = {4'd9, 4'd9, 4'd9};
        end
        tick("s1g");
        check("s1.gap_done", 32'(done), 32'(3'b001));
        check("s1.gap_rgb",  32'(rgb),  32'(3'b000));
        req = 3'b000;
        tick("s1i");
        check("s1.idle_busy", 32'(busy), 32'h0);

        // Round-robin with all requests held and dwell 1.
        do_reset();
        dwell = {3{4'd1}};
        req   = 3'b111;
        prev  = 3'b000;
        last_start = 0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick("s2");
            if (gnt != 3'b000 && prev == 3'b000) begin
                order.push_back(oh_idx(gnt));
                if (order.size() > 1) check("s2.spacing", 32'(c - last_start), 32'd3);
                last_start = c;
            end
            prev = gnt;
        end
        check("s2.count", 32'(order.size()), 32'd5);
        foreach (order[i]) check("s2.order", 32'(order[i]), PRIO ? 32'd0 : 32'(i % 3));
        req = 3'b000;
        tick("s2e");
        tick("s2e");

        // dwell = 0 gives a single SHOW cycle.
        do_reset();
        dwell = {4'd5, 4'd0, 4'd5};
        req   = 3'b010;
        tick("s3");
        check("s3.gnt", 32'(gnt), 32'(3'b010));
        tick("s3");
        check("s3.done", 32'(done), 32'(3'b010));
        req = 3'b000;
        tick("s3e");

        // Abort of requester 2 at SHOW cycle 3; pointer must still have moved past 2.
        dwell = {4'd8, 4'd1, 4'd1};
        req   = 3'b100;
        tick("s4");
        check("s4.gnt", 32'(gnt), 32'(3'b100));
        tick("s4");
        tick("s4");
        req = 3'b000;
        tick("s4a");
        check("s4.abort_done", 32'(done), 32'h0);
        check("s4.abort_busy", 32'(busy), 32'h1);
        tick("s4i");
        req = 3'b110;
        tick("s4n");
        check("s4.next_gnt", 32'(gnt), 32'(3'b010));
        req = 3'b000;
        tick("s4e");
        tick("s4e");

        // Reset during SHOW cycle 2.
        do_reset();
        dwell = {3{4'd5}};
        req   = 3'b111;
        tick("s5");
        tick("s5");
        reset = 1'b1;
        tick("s5r");
        check("s5.rst_gnt",  32'(gnt),  32'h0);
        check("s5.rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        tick("s5n");
        check("s5.regrant", 32'(gnt), 32'(3'b001));
        check("s5.no_done", 32'(done), 32'h0);

        // Randomized traffic: sticky requests, inputs changing every cycle, rare resets.
        req = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 299) == 0);
            req    = req ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
            colour = 9'($urandom);
            for (int i = 0; i < 3; i++) begin
                dwell[HOLD_W*i +: HOLD_W] = ($urandom_range(0, 7) == 0) ? HOLD_W'($urandom)
                                                                       : HOLD_W'($urandom_range(0, 3));
            end
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
